// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with run-time fixed-select or round-robin grant and a one-entry output register.
// Optional packet lock (IN_LAST/OUT_LAST) is compiled in with `define MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  input  logic           MODE,
  input  logic [SW-1:0]  SEL,
  output logic [W-1:0]   OUT_DATA,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
`ifdef MUX_PKT_LOCK_EN
  input  logic [N-1:0]   IN_LAST,
  output logic           OUT_LAST,
`endif
  output logic [SW-1:0]  OUT_CH
);

  // First valid channel after p, scanning upward modulo N; MSB flags a hit.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] v, input logic [SW-1:0] p);
    logic [SW:0] pick;
    int          j;
    pick = '0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(p) + i) % N;
      if (!pick[SW] && v[j]) begin
        pick[SW]     = 1'b1;
        pick[SW-1:0] = SW'(j);
      end
    end
    return pick;
  endfunction

  logic [(2**SW)-1:0] vld_ext_p0;
  logic               can_load_p0;
  logic               gnt_vld_p0;
  logic [SW-1:0]      gnt_p0;
  logic               xfer_p0;
  logic [W-1:0]       data_p0;
  logic [SW:0]        rr_p0;

  logic               vld_p1;
  logic [W-1:0]       data_p1;
  logic [SW-1:0]      ch_p1;
  logic [SW-1:0]      ptr;
`ifdef MUX_PKT_LOCK_EN
  logic               locked;
  logic               last_p0;
  logic               last_p1;
`endif

  // Stage p0: grant decision and input handshake
  always_comb begin
    vld_ext_p0  = (2**SW)'(IN_VALID);
    can_load_p0 = !vld_p1 || OUT_READY;
    rr_p0       = rr_pick(IN_VALID, ptr);
    gnt_vld_p0  = 1'b0;
    gnt_p0      = '0;
    if (!MODE) begin
      // Out-of-range SEL lands on the zero-extended bits and never grants.
      gnt_vld_p0 = vld_ext_p0[SEL];
      gnt_p0     = SEL;
    end else begin
      gnt_vld_p0 = rr_p0[SW];
      gnt_p0     = rr_p0[SW-1:0];
    end
`ifdef MUX_PKT_LOCK_EN
    // Mid-packet: only the owning channel (still shown on OUT_CH) may continue.
    if (locked) begin
      gnt_p0     = ch_p1;
      gnt_vld_p0 = vld_ext_p0[ch_p1];
    end
`endif
    xfer_p0  = gnt_vld_p0 && can_load_p0;
    IN_READY = '0;
    data_p0  = '0;
`ifdef MUX_PKT_LOCK_EN
    last_p0  = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (gnt_p0 == SW'(i)) begin
        IN_READY[i] = xfer_p0;
        data_p0     = IN_DATA[i*W +: W];
`ifdef MUX_PKT_LOCK_EN
        last_p0     = IN_LAST[i];
`endif
      end
    end
  end

  // Stage p1: output register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= SW'(N-1);
`ifdef MUX_PKT_LOCK_EN
      locked  <= 1'b0;
      last_p1 <= 1'b0;
`endif
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      ch_p1   <= gnt_p0;
      ptr     <= gnt_p0;
`ifdef MUX_PKT_LOCK_EN
      locked  <= !last_p0;
      last_p1 <= last_p0;
`endif
    end else if (OUT_READY) begin
      vld_p1 <= 1'b0;
    end
  end

  assign OUT_VALID = vld_p1;
  assign OUT_DATA  = data_p1;
  assign OUT_CH    = ch_p1;
`ifdef MUX_PKT_LOCK_EN
  assign OUT_LAST  = last_p1;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N=4, W=8): reset, fixed select, round-robin, back-pressure,
// randomised mode switching against a cycle model, and packet lock when MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_ch;
  logic [N-1:0]   in_last;
  logic           out_last;

  int n_checks = 0;
  int n_fail   = 0;

  stream_mux_rr #(.N(N), .W(W), .SW(SW)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .IN_DATA(in_data),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .MODE(mode),
    .SEL(sel),
    .OUT_DATA(out_data),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
`ifdef MUX_PKT_LOCK_EN
    .IN_LAST(in_last),
    .OUT_LAST(out_last),
`endif
    .OUT_CH(out_ch)
  );

`ifndef MUX_PKT_LOCK_EN
  assign out_last = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid  = '0;
    out_ready = 1'b0;
    in_last   = '0;
    rst_n     = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; mode = 1'b0; sel = '0; in_last = '0;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick(); tick();
    if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b want 0", out_valid); n_fail++; end
    n_checks++;
    rst_n = 1'b1;
    in_valid = 4'b0001;
    tick();
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      $display("FAIL preload: valid %0b data %h want 1 a0", out_valid, out_data); n_fail++;
    end
    n_checks++;
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      $display("FAIL async_reset: valid %0b data %h ch %0d want 0 00 0", out_valid, out_data, out_ch); n_fail++;
    end
    n_checks++;
    in_valid = '0;
    #1 rst_n = 1'b1;
    tick();
    if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      $display("FAIL idle_ready: in_ready %b valid %0b want 0000 0", in_ready, out_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_fixed;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    if (in_ready !== 4'b0100) begin $display("FAIL fixed_ready0: got %b want 0100", in_ready); n_fail++; end
    n_checks++;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 8'hA2 || out_ch !== 2'd2 || in_ready !== 4'b0100) begin
        $display("FAIL fixed_word%0d: valid %0b data %h ch %0d rdy %b want 1 a2 2 0100",
                 k, out_valid, out_data, out_ch, in_ready); n_fail++;
      end
      n_checks++;
    end
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    if (in_ready !== 4'b0000) begin $display("FAIL fixed_nogrant_ready: got %b want 0000", in_ready); n_fail++; end
    n_checks++;
    tick();
    if (out_valid !== 1'b0 || out_data !== 8'hA2 || out_ch !== 2'd2) begin
      $display("FAIL fixed_drop: valid %0b data %h ch %0d want 0 a2 2", out_valid, out_data, out_ch); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_rr;
    logic [SW-1:0] exp_all [6];
    logic [SW-1:0] exp_alt [4];
    exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_alt = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_ch !== exp_all[k] || out_data !== 8'hA0 + 8'(exp_all[k])) begin
        $display("FAIL rr_all%0d: valid %0b ch %0d data %h want ch %0d", k, out_valid, out_ch, out_data, exp_all[k]);
        n_fail++;
      end
      n_checks++;
    end
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_ch !== exp_alt[k] || out_data !== 8'hA0 + 8'(exp_alt[k])) begin
        $display("FAIL rr_alt%0d: valid %0b ch %0d data %h want ch %0d", k, out_valid, out_ch, out_data, exp_alt[k]);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_ch !== 2'd0) begin
      $display("FAIL bp_first: valid %0b data %h ch %0d want 1 a0 0", out_valid, out_data, out_ch); n_fail++;
    end
    n_checks++;
    for (int k = 0; k < 5; k++) begin
      mode = ~mode; sel = 2'(k);
      #1;
      if (in_ready !== 4'b0000) begin $display("FAIL bp_ready%0d: got %b want 0000", k, in_ready); n_fail++; end
      n_checks++;
      tick();
      if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_ch !== 2'd0) begin
        $display("FAIL bp_hold%0d: valid %0b data %h ch %0d want 1 a0 0", k, out_valid, out_data, out_ch); n_fail++;
      end
      n_checks++;
    end
    mode = 1'b1; out_ready = 1'b1;
    #1;
    if (in_ready !== 4'b0010) begin $display("FAIL bp_release_ready: got %b want 0010", in_ready); n_fail++; end
    n_checks++;
    tick();
    if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_ch !== 2'd1) begin
      $display("FAIL bp_next: valid %0b data %h ch %0d want 1 a1 1", out_valid, out_data, out_ch); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_mode_switch;
    logic [SW-1:0] mptr, mch, g;
    logic          mvalid, gv, can;
    logic [W-1:0]  mdata;
    logic [5:0]    cnt [N];
    logic [N-1:0]  exp_rdy;
    int            pushes, pops;
    do_reset();
    mptr = 2'd3; mch = '0; mvalid = 1'b0; mdata = '0; pushes = 0; pops = 0;
    for (int i = 0; i < N; i++) cnt[i] = '0;
    mode = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      mode      = ~mode;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {2'(i), cnt[i]};
      gv = 1'b0; g = '0;
      if (!mode) begin
        gv = in_valid[sel]; g = sel;
      end else begin
        for (int s = 1; s <= N; s++) begin
          if (!gv && in_valid[(int'(mptr) + s) % N]) begin gv = 1'b1; g = 2'((int'(mptr) + s) % N); end
        end
      end
      can = !mvalid || out_ready;
      exp_rdy = (gv && can) ? (4'b0001 << g) : 4'b0000;
      #1;
      if (in_ready !== exp_rdy) begin
        $display("FAIL ms_ready c%0d: got %b want %b", c, in_ready, exp_rdy); n_fail++;
      end
      n_checks++;
      if (mvalid && out_ready) pops++;
      if (gv && can) begin
        mdata = {g, cnt[g]}; mch = g; mvalid = 1'b1; mptr = g; cnt[g] = cnt[g] + 6'd1; pushes++;
      end else if (out_ready) begin
        mvalid = 1'b0;
      end
      tick();
      if (out_valid !== mvalid || (mvalid && (out_data !== mdata || out_ch !== mch))) begin
        $display("FAIL ms_out c%0d: valid %0b data %h ch %0d want %0b %h %0d",
                 c, out_valid, out_data, out_ch, mvalid, mdata, mch); n_fail++;
      end
      n_checks++;
    end
    if (pushes - pops !== int'(mvalid) || pushes < 500) begin
      $display("FAIL ms_count: pushes %0d pops %0d held %0b", pushes, pops, mvalid); n_fail++;
    end
    n_checks++;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

`ifdef MUX_PKT_LOCK_EN
  task automatic test_pkt_lock;
    logic [N-1:0] vseq [5];
    logic [N-1:0] lseq [5];
    logic         evld [5];
    logic [SW-1:0] ech [5];
    vseq = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011};
    lseq = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    evld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ech  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = vseq[k]; in_last = lseq[k];
      #1;
      if (in_ready !== (evld[k] ? (4'b0001 << ech[k]) : 4'b0000)) begin
        $display("FAIL lock_ready%0d: got %b", k, in_ready); n_fail++;
      end
      n_checks++;
      tick();
      if (out_valid !== evld[k] || (evld[k] && out_ch !== ech[k])) begin
        $display("FAIL lock_out%0d: valid %0b ch %0d want %0b %0d", k, out_valid, out_ch, evld[k], ech[k]); n_fail++;
      end
      n_checks++;
    end
    in_last = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_mode_switch();
`ifdef MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
N-channel, W-bit successor to the 2:1 mux.
- Merges N valid/ready input streams onto one registered output stream.
- Selection mode is chosen at run time: fixed select (SEL drives selection, as in the 2:1 mux) or round-robin arbitration.
- Sits between multiple producers and a single consumer.
- Output is a one-entry register stage, giving full throughput and back-pressure.

Parameters:
N, 4, number of input channels (N >= 2)
W, 8, data width per channel
SW, 2, select/channel-index width; must equal $clog2(N)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous reset, active low
IN_DATA  input  N*W  channel i data at [i*W +: W]
IN_VALID  input  N  per-channel valid
IN_READY  output  N  per-channel ready (one-hot or zero)
MODE  input  1  0 = fixed select, 1 = round-robin
SEL  input  SW  channel index used when MODE=0
OUT_DATA  output  W  registered output data
OUT_VALID  output  1  output valid
OUT_READY  input  1  consumer ready
OUT_CH  output  SW  source channel of the current OUT_DATA

Behaviour:
- Reset (RST_N=0, async): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, round-robin pointer PTR=N-1, so channel 0 has first priority.
- Transfer rule: a transfer occurs on any interface where valid & ready are both high at a rising CLK edge.
- can_load = !OUT_VALID | OUT_READY.
- Grant g (combinational, at most one channel):
  - MODE=0: g=SEL if SEL<N and IN_VALID[SEL]=1; otherwise no grant. SEL>=N never grants.
  - MODE=1: scan channels PTR+1, PTR+2, ... modulo N; g is the first channel with IN_VALID=1.
- IN_READY[g] = can_load; all other IN_READY bits = 0.
  - IN_READY depends combinationally on OUT_READY; there is no combinational path from IN_VALID to any input's own IN_READY other than through the grant.
- On input transfer: OUT_DATA<=IN_DATA[g], OUT_CH<=g, OUT_VALID<=1, PTR<=g. PTR updates in both modes.
- No grant and OUT_READY=1: OUT_VALID<=0; OUT_DATA and OUT_CH hold their last values.
- Stall (OUT_VALID=1, OUT_READY=0):
  - OUT_DATA and OUT_CH are held stable.
  - All IN_READY = 0.
  - Changes on SEL, MODE or inputs have no effect on the held word.
- Latency: 1 cycle from input transfer to OUT_VALID.
- Throughput: 1 word/cycle with OUT_READY held high.
- Round-robin fairness: with all N channels valid continuously, grants follow 0,1,...,N-1,0,... with no channel starved for more than N-1 grants.
- MODE change: takes effect at the next grant decision; PTR is not reset.
- Reset mid-operation: the held output word is discarded and any in-flight input handshake is void.
- Wrap-around: PTR=N-1 scans starting from channel 0.

Optional Feature:
Macro MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports IN_LAST (input, N) and OUT_LAST (output, 1, registered with the data, reset 0).
  - After a transfer from channel c with IN_LAST[c]=0, the grant is locked to c in both modes; SEL and PTR scan are ignored.
  - While locked, no other channel is granted, even if c is idle.
  - The lock clears after a transfer with IN_LAST[c]=1.
  - RST_N clears the lock.
- Undefined: no IN_LAST/OUT_LAST ports; arbitration is per word; behaviour as above.

Test Plan:
- Reset/idle: assert RST_N=0 mid-stream with OUT_VALID=1 -> OUT_VALID=0, OUT_CH=0, OUT_DATA=0 immediately. After release with no IN_VALID -> all IN_READY=0.
- Fixed select: MODE=0, SEL=2, IN_VALID=4'b1111, IN_DATA ch i = 8'hA0+i, OUT_READY=1 -> OUT_DATA=8'hA2, OUT_CH=2 every cycle; IN_READY=4'b0100. With SEL=3 and IN_VALID[3]=0 -> OUT_VALID drops after 1 cycle.
- Round-robin: MODE=1, all channels valid, OUT_READY=1, from reset -> OUT_CH sequence 0,1,2,3,0,1. With IN_VALID=4'b1010 -> sequence 1,3,1,3.
- Back-pressure: MODE=1, OUT_READY=0 for 5 cycles after the first word (8'hA0) -> OUT_DATA=8'hA0 held, IN_READY=0. On release, the next word comes from channel 1 with no word lost or duplicated.
- Mode switch: alternate MODE each cycle with random IN_VALID and OUT_READY over 2000 cycles -> scoreboard checks per-channel order, no loss, OUT_CH correct.
- MUX_PKT_LOCK_EN: MODE=1, ch0 sends 3 words with LAST on word 3, ch1 always valid -> OUT_CH=0,0,0,1. An idle gap on ch0 mid-packet -> ch1 is not granted until ch0's LAST word transfers.
